// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared issuer state type, default widths and ALU opcodes
package alu_pkg;

  localparam int ALU_OP_W   = 3;
  localparam int ALU_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } issuer_state_e;

  localparam logic [ALU_OP_W-1:0] OP_NOP = 3'd0;
  localparam logic [ALU_OP_W-1:0] OP_ADD = 3'd1;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 3'd2;
  localparam logic [ALU_OP_W-1:0] OP_AND = 3'd3;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 3'd4;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 3'd5;
  localparam logic [ALU_OP_W-1:0] OP_SHL = 3'd6;
  localparam logic [ALU_OP_W-1:0] OP_SHR = 3'd7;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command FIFO with combinational head read
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers are AW bits wide, so wrap modulo DEPTH falls out of the adder.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - buffers ALU commands, issues one at a time, returns result or timeout
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int OP_W    = ALU_OP_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [OP_W-1:0]        cmd_op_i,
  input  logic [DATA_W-1:0]      cmd_a_i,
  input  logic [DATA_W-1:0]      cmd_b_i,
  output logic                   alu_start_o,
  output logic [OP_W-1:0]        alu_op_o,
  output logic [DATA_W-1:0]      alu_a_o,
  output logic [DATA_W-1:0]      alu_b_o,
  input  logic                   alu_rvalid_i,
  input  logic [DATA_W-1:0]      alu_result_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [DATA_W-1:0]      res_data_o,
  output logic                   res_err_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] cmd_count_o
);

  localparam int FW = OP_W + 2 * DATA_W;
  localparam int TW = $clog2(TIMEOUT);

  issuer_state_e     state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_err_q, res_err_d;
  logic [TW-1:0]     timer_q, timer_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_rdata;

  assign fifo_push = cmd_valid_i && !fifo_full;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({cmd_op_i, cmd_a_i, cmd_b_i}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (cmd_count_o)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    timer_d    = timer_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          {op_d, a_d, b_d} = fifo_rdata;
          fifo_pop         = 1'b1;
          state_d          = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + TW'(1);
        // A response on the last allowed cycle still counts as a real result.
        if (alu_rvalid_i) begin
          res_data_d = alu_result_i;
          res_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      timer_q    <= timer_d;
    end
  end

  assign cmd_ready_o = !fifo_full;
  assign alu_start_o = (state_q == ST_ISSUE);
  assign alu_op_o    = op_q;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign res_valid_o = (state_q == ST_RESP);
  assign res_data_o  = res_data_q;
  assign res_err_o   = res_err_q;
  assign busy_o      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - directed self-checking bench for alu_cmd_issuer
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  logic       clk_i = 1'b0;
  logic       reset_i, cmd_valid_i, res_ready_i;
  logic [2:0] cmd_op_i;
  logic [7:0] cmd_a_i, cmd_b_i;
  logic       alu_rvalid_i;
  logic [7:0] alu_result_i;
  logic       cmd_ready_o, alu_start_o, res_valid_o, res_err_o, busy_o;
  logic [2:0] alu_op_o, cmd_count_o;
  logic [7:0] alu_a_o, alu_b_o, res_data_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  alu_cmd_issuer #(.DATA_W(8), .OP_W(3), .DEPTH(4), .TIMEOUT(15)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op_i),
    .cmd_a_i      (cmd_a_i),
    .cmd_b_i      (cmd_b_i),
    .alu_start_o  (alu_start_o),
    .alu_op_o     (alu_op_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_rvalid_i (alu_rvalid_i),
    .alu_result_i (alu_result_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_data_o   (res_data_o),
    .res_err_o    (res_err_o),
    .busy_o       (busy_o),
    .cmd_count_o  (cmd_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Controller model: rvalid arrives ctl_lat cycles after the start pulse.
  int         ctl_cnt = 0;
  int         ctl_lat = 3;
  bit         ctl_en  = 1'b1;
  logic       ctl_rvalid = 1'b0, tb_rvalid = 1'b0;
  logic [7:0] ctl_result = '0, tb_result = '0;
  logic [2:0] ctl_op = '0;
  logic [7:0] ctl_a = '0, ctl_b = '0;

  assign alu_rvalid_i = ctl_rvalid | tb_rvalid;
  assign alu_result_i = tb_rvalid ? tb_result : ctl_result;

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << b[2:0];
      OP_SHR:  return a >> b[2:0];
      OP_NOP:  return 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge clk_i) begin
    ctl_rvalid = 1'b0;
    if (reset_i) begin
      ctl_cnt = 0;
    end else begin
      if (ctl_cnt > 0) begin
        ctl_cnt = ctl_cnt - 1;
        if (ctl_cnt == 0 && ctl_en) begin
          ctl_rvalid = 1'b1;
          ctl_result = alu_ref(ctl_op, ctl_a, ctl_b);
        end
      end
      if (alu_start_o) begin
        ctl_cnt = ctl_lat;
        ctl_op  = alu_op_o;
        ctl_a   = alu_a_o;
        ctl_b   = alu_b_o;
      end
    end
  end

  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_a_i = a; cmd_b_i = b;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_res();
    int n = 0;
    while (!res_valid_o && n < 100) begin @(negedge clk_i); n++; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 200) begin @(negedge clk_i); n++; end
  endtask

  task automatic measure(output int n);
    int guard = 0;
    n = 0;
    while (!alu_start_o && guard < 20) begin @(negedge clk_i); guard++; end
    while (!res_valid_o && n < 60) begin @(negedge clk_i); n++; end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; cmd_valid_i = 1'b0; res_ready_i = 1'b1;
    cmd_op_i = '0; cmd_a_i = '0; cmd_b_i = '0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    chk_cnt++;
    if ({cmd_ready_o, alu_start_o, res_valid_o, res_err_o, busy_o} !== 5'b10000)
      $display("FAIL reset_flags: got %b expected 10000", {cmd_ready_o, alu_start_o, res_valid_o, res_err_o, busy_o});
    else pass_cnt++;
    chk_cnt++;
    if (cmd_count_o !== 3'd0) $display("FAIL reset_count: got %0d expected 0", cmd_count_o);
    else pass_cnt++;
    chk_cnt++;
    if ({alu_op_o, alu_a_o, alu_b_o, res_data_o} !== 27'd0)
      $display("FAIL reset_data: got %h expected 0", {alu_op_o, alu_a_o, alu_b_o, res_data_o});
    else pass_cnt++;
  endtask

  task automatic test_single();
    int n_start = 0, start_cyc = 0, rv_cyc = 0;
    push(3'b001, 8'h12, 8'h34);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_i);
      if (alu_start_o) begin n_start++; start_cyc = k; end
      if (res_valid_o && rv_cyc == 0) rv_cyc = k;
    end
    chk_cnt++;
    if (start_cyc !== 1 || n_start !== 1)
      $display("FAIL single_start: got cycle %0d count %0d expected cycle 1 count 1", start_cyc, n_start);
    else pass_cnt++;
    chk_cnt++;
    if (rv_cyc !== 5) $display("FAIL single_latency: got %0d expected 5", rv_cyc);
    else pass_cnt++;
    chk_cnt++;
    if (res_data_o !== 8'h46 || res_err_o !== 1'b0)
      $display("FAIL single_result: got %h err %b expected 46 err 0", res_data_o, res_err_o);
    else pass_cnt++;
    @(negedge clk_i);
    wait_idle();
  endtask

  task automatic test_fifo_full();
    logic [2:0] ops [5] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    logic [7:0] as  [5] = '{8'h10, 8'h50, 8'hFF, 8'h0F, 8'hFF};
    logic [7:0] bs  [5] = '{8'h20, 8'h08, 8'h5A, 8'hA0, 8'h0F};
    logic [7:0] exp_r [5] = '{8'h30, 8'h48, 8'h5A, 8'hAF, 8'hF0};
    int extra = 0;
    res_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid_i = 1'b1; cmd_op_i = ops[i]; cmd_a_i = as[i]; cmd_b_i = bs[i];
      @(negedge clk_i);
    end
    chk_cnt++;
    if (cmd_count_o !== 3'd4 || cmd_ready_o !== 1'b0)
      $display("FAIL full_state: got count %0d ready %b expected 4 0", cmd_count_o, cmd_ready_o);
    else pass_cnt++;
    cmd_op_i = OP_ADD; cmd_a_i = 8'h77; cmd_b_i = 8'h11;
    repeat (3) @(negedge clk_i);
    cmd_valid_i = 1'b0;
    chk_cnt++;
    if (cmd_count_o !== 3'd4 || cmd_ready_o !== 1'b0 || res_valid_o !== 1'b1)
      $display("FAIL full_hold: got count %0d ready %b rvalid %b expected 4 0 1", cmd_count_o, cmd_ready_o, res_valid_o);
    else pass_cnt++;
    res_ready_i = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wait_res();
      chk_cnt++;
      if (res_valid_o !== 1'b1 || res_data_o !== exp_r[j] || res_err_o !== 1'b0)
        $display("FAIL full_drain%0d: got valid %b data %h err %b expected 1 %h 0", j, res_valid_o, res_data_o, res_err_o, exp_r[j]);
      else pass_cnt++;
      @(negedge clk_i);
    end
    for (int k = 0; k < 10; k++) begin
      if (res_valid_o || alu_start_o) extra++;
      @(negedge clk_i);
    end
    chk_cnt++;
    if (extra !== 0) $display("FAIL full_no_extra: got %0d extra cycles expected 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       e;
    int bad = 0, starts = 0, start_cyc = 0;
    res_ready_i = 1'b0;
    push(OP_SUB, 8'h05, 8'h07);
    push(OP_ADD, 8'h7F, 8'h01);
    wait_res();
    d = res_data_o; e = res_err_o;
    chk_cnt++;
    if (res_valid_o !== 1'b1 || d !== 8'hFE || e !== 1'b0)
      $display("FAIL bp_first: got valid %b data %h err %b expected 1 fe 0", res_valid_o, d, e);
    else pass_cnt++;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      if (res_data_o !== d || res_err_o !== e || !res_valid_o) bad++;
      if (alu_start_o) starts++;
    end
    chk_cnt++;
    if (bad !== 0 || starts !== 0)
      $display("FAIL bp_stable: got %0d unstable %0d starts expected 0 0", bad, starts);
    else pass_cnt++;
    res_ready_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      if (alu_start_o && start_cyc == 0) start_cyc = k;
    end
    chk_cnt++;
    if (start_cyc !== 2) $display("FAIL bp_next_issue: got cycle %0d expected 2", start_cyc);
    else pass_cnt++;
    wait_res();
    chk_cnt++;
    if (res_data_o !== 8'h80 || res_err_o !== 1'b0)
      $display("FAIL bp_second: got %h err %b expected 80 0", res_data_o, res_err_o);
    else pass_cnt++;
    @(negedge clk_i);
    wait_idle();
  endtask

  task automatic test_timeout();
    int n;
    ctl_en = 1'b0;
    push(OP_ADD, 8'h01, 8'h01);
    measure(n);
    chk_cnt++;
    if (n !== 16 || res_err_o !== 1'b1 || res_data_o !== 8'h00)
      $display("FAIL timeout: got %0d cycles err %b data %h expected 16 1 00", n, res_err_o, res_data_o);
    else pass_cnt++;
    @(negedge clk_i);
    ctl_en = 1'b1;
    push(OP_ADD, 8'h21, 8'h21);
    wait_res();
    chk_cnt++;
    if (res_valid_o !== 1'b1 || res_data_o !== 8'h42 || res_err_o !== 1'b0)
      $display("FAIL timeout_recover: got valid %b data %h err %b expected 1 42 0", res_valid_o, res_data_o, res_err_o);
    else pass_cnt++;
    @(negedge clk_i);
    wait_idle();
  endtask

  task automatic test_spurious();
    int bad = 0;
    tb_result = 8'hEE; tb_rvalid = 1'b1;
    @(negedge clk_i);
    tb_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (res_valid_o || busy_o || alu_start_o) bad++;
      @(negedge clk_i);
    end
    chk_cnt++;
    if (bad !== 0 || res_data_o !== 8'h42)
      $display("FAIL spurious_idle: got %0d active cycles data %h expected 0 42", bad, res_data_o);
    else pass_cnt++;
  endtask

  task automatic test_rvalid_at_limit();
    int n;
    ctl_lat = 15;
    push(OP_XOR, 8'h3C, 8'hFF);
    measure(n);
    chk_cnt++;
    if (n !== 16 || res_err_o !== 1'b0 || res_data_o !== 8'hC3)
      $display("FAIL limit_rvalid: got %0d cycles err %b data %h expected 16 0 c3", n, res_err_o, res_data_o);
    else pass_cnt++;
    @(negedge clk_i);
    ctl_lat = 16;
    push(OP_OR, 8'h40, 8'h05);
    measure(n);
    chk_cnt++;
    if (n !== 16 || res_err_o !== 1'b1 || res_data_o !== 8'h00)
      $display("FAIL limit_late: got %0d cycles err %b data %h expected 16 1 00", n, res_err_o, res_data_o);
    else pass_cnt++;
    @(negedge clk_i);
    ctl_lat = 3;
    wait_idle();
  endtask

  task automatic test_reset_mid_wait();
    int extra = 0;
    ctl_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid_i = 1'b1; cmd_op_i = OP_ADD; cmd_a_i = 8'(i); cmd_b_i = 8'h10;
      @(negedge clk_i);
    end
    cmd_valid_i = 1'b0;
    chk_cnt++;
    if (cmd_count_o !== 3'd3 || alu_start_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL pre_reset: got count %0d start %b busy %b expected 3 0 1", cmd_count_o, alu_start_o, busy_o);
    else pass_cnt++;
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    chk_cnt++;
    if (cmd_count_o !== 3'd0 || {busy_o, res_valid_o, alu_start_o, cmd_ready_o} !== 4'b0001)
      $display("FAIL mid_reset: got count %0d flags %b expected 0 0001", cmd_count_o, {busy_o, res_valid_o, alu_start_o, cmd_ready_o});
    else pass_cnt++;
    ctl_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (res_valid_o || alu_start_o) extra++;
      @(negedge clk_i);
    end
    push(OP_ADD, 8'h02, 8'h03);
    wait_res();
    chk_cnt++;
    if (extra !== 0 || res_data_o !== 8'h05 || res_err_o !== 1'b0)
      $display("FAIL post_reset: got %0d stray cycles data %h err %b expected 0 05 0", extra, res_data_o, res_err_o);
    else pass_cnt++;
    @(negedge clk_i);
  endtask

  initial begin
    reset_i = 1'b1; cmd_valid_i = 1'b0; res_ready_i = 1'b1;
    cmd_op_i = '0; cmd_a_i = '0; cmd_b_i = '0;
    @(negedge clk_i);
    test_reset();
    test_single();
    test_fifo_full();
    test_back_to_back();
    test_timeout();
    test_spurious();
    test_rvalid_at_limit();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command-side sequencer for the ALU controller. Accepts ALU commands (opcode plus two operands) over a valid/ready interface, buffers them in a small FIFO, and issues each one to the ALU as a single-cycle `alu_start` pulse with stable operands. It waits for the controller's `rvalid`, captures the result, and presents it downstream over a valid/ready interface. A timeout reports an ALU that never answers.

## Interface
- `DATA_W`, 8, operand/result width
- `OP_W`, 3, opcode width
- `DEPTH`, 4, command FIFO entries (power of two, ≥2)
- `TIMEOUT`, 15, max cycles spent in WAIT before error (≥4)

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  upstream command valid
- `cmd_ready`  out  1  FIFO not full
- `cmd_op`  in  OP_W  opcode
- `cmd_a`, `cmd_b`  in  DATA_W  operands
- `alu_start`  out  1  one-cycle start pulse to controller
- `alu_op`  out  OP_W  opcode to ALU, held from ISSUE through WAIT
- `alu_a`, `alu_b`  out  DATA_W  operands to ALU, held from ISSUE through WAIT
- `alu_rvalid`  in  1  result valid from controller
- `alu_result`  in  DATA_W  ALU result, sampled when `alu_rvalid`=1
- `res_valid`  out  1  result available downstream
- `res_ready`  in  1  downstream accepts
- `res_data`  out  DATA_W  captured result
- `res_err`  out  1  1 = timeout, and `res_data`=0
- `busy`  out  1  state ≠ IDLE or FIFO non-empty
- `cmd_count`  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset: FIFO empty, state IDLE, timer 0. All outputs 0, except `cmd_ready`=1.
- FIFO
  - Push when `cmd_valid & cmd_ready`. `cmd_ready` = !full; there is no same-cycle bypass when full.
  - Pop occurs on the IDLE→ISSUE transition.
  - Simultaneous push and pop leaves `cmd_count` unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO is non-empty, load head into `alu_op/a/b`, pop, and go to ISSUE.
  - ISSUE: `alu_start`=1 for exactly this cycle. Clear timer. Go to WAIT.
  - WAIT: timer increments each cycle.
    - If `alu_rvalid`=1: capture `alu_result` into `res_data`, set `res_err`=0, go to RESP.
    - Else if timer = TIMEOUT-1: set `res_data`=0 and `res_err`=1, go to RESP.
    - If `alu_rvalid` and the timeout limit occur in the same cycle, `alu_rvalid` wins.
  - RESP: `res_valid`=1. `res_data` and `res_err` are stable until `res_ready`=1, then go to IDLE.
- `alu_rvalid` outside WAIT is ignored.
- At most one command is outstanding at the ALU, so `alu_start` is never asserted while the controller is mid-sequence on a valid response path.
- Reset in any state returns everything to reset values on the next edge and discards both FIFO contents and any in-flight result.

## Timing
- Command pushed into an empty FIFO at edge t (issuer in IDLE):
  - cycle t+1: `alu_start`=1 (ISSUE).
  - cycles t+2..t+4: WAIT. The controller passes through LOAD (t+2), EXECUTE (t+3), and MEM_WRITE with `rvalid`=1 (t+4).
  - cycle t+5: `res_valid`=1.
- Minimum command-to-result latency is 5 cycles.
- If `res_ready` is held high, the next issue follows 2 cycles after `res_valid` (RESP→IDLE→ISSUE). Back-to-back throughput is one command per 6 cycles.
- `res_valid` is registered. `cmd_ready` depends only on registered occupancy, with no combinational path from inputs.
- Timeout: with no `alu_rvalid`, RESP is entered after exactly TIMEOUT cycles in WAIT.

## Structure
- Shared package `alu_pkg`:
  - issuer state enum (IDLE/ISSUE/WAIT/RESP)
  - `OP_W` and `DATA_W` defaults
  - opcode constants shared with the ALU datapath
- Sub-module `alu_cmd_fifo` (parameters DEPTH, width OP_W+2·DATA_W):
  - ports: push, pop, wdata, rdata, full, empty, count
  - first-word read data is combinational from the head entry
- Top module holds the FSM, operand/result registers and timeout counter.

## Test plan
- Single command: push op=3'b001, a=8'h12, b=8'h34, with a controller model returning 8'h46.
  - Required: `alu_start` high one cycle at t+1, `res_valid` at t+5, `res_data`=8'h46, `res_err`=0.
- FIFO full: push 5 commands with the result path stalled (`res_ready`=0).
  - Required: `cmd_ready`=0 and `cmd_count`=4 while full.
  - Required: results drain in push order once `res_ready`=1.
- Backpressure: hold `res_ready`=0 for 10 cycles.
  - Required: `res_data` and `res_err` stay stable.
  - Required: no second `alu_start` until the handshake completes.
- Timeout: controller model never asserts `rvalid`.
  - Required: `res_valid` with `res_err`=1 and `res_data`=0 after TIMEOUT (15) cycles in WAIT.
  - Required: a subsequent command still completes normally.
- Spurious and edge cases:
  - `alu_rvalid` pulsed in IDLE is ignored.
  - `alu_rvalid` in the same cycle as the timeout limit yields `res_err`=0.
- Reset mid-WAIT with 3 commands queued.
  - Required next cycle: `cmd_count`=0, `busy`=0, `res_valid`=0, `alu_start`=0, `cmd_ready`=1.
